// File: rtl/frac_strobe_monitor.sv
// Receive-side checker for a fractional-rate strobe train: measures strobe intervals
// and per-window totals, flags illegal spacing, and reports lock after clean windows.
module frac_strobe_monitor #(
  parameter int SOURCE_NUM   = 76,
  parameter int DEST_NUM     = 10,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strobe_in,
  input  logic        clear,
  output logic [7:0]  interval,
  output logic        interval_vld,
  output logic [15:0] window_total,
  output logic        window_vld,
  output logic        locked,
  output logic        err_interval,
  output logic        err_total,
  output logic [7:0]  err_cnt
);

  localparam int SDIV = SOURCE_NUM / DEST_NUM;
  localparam logic [7:0]  K_LO     = 8'(SDIV);
  localparam logic [7:0]  K_HI     = 8'(SDIV + 1);
  localparam logic [7:0]  LAST_IDX = 8'(DEST_NUM - 1);
  localparam logic [7:0]  LOCK_MAX = 8'(LOCK_WINDOWS);
  localparam logic [15:0] SRC_TOT  = 16'(SOURCE_NUM);

  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, TRACK = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [7:0]  gap_r, gap_s;
  logic [7:0]  idx_r, idx_s;
  logic [15:0] sum_r, sum_s;
  logic [7:0]  lock_cnt_r, lock_cnt_s;
  logic [15:0] win_sum_s;
  logic [7:0]  lock_inc_s;
  logic [7:0]  interval_s;
  logic        interval_vld_s;
  logic [15:0] window_total_s;
  logic        window_vld_s;
  logic        locked_s;
  logic        err_interval_s;
  logic        err_total_s;
  logic [7:0]  err_cnt_s;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [7:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {9'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Next-state and next-output computation; gap holds cycles elapsed since the last strobe.
  always_comb begin
    state_s        = state_r;
    gap_s          = gap_r;
    idx_s          = idx_r;
    sum_s          = sum_r;
    lock_cnt_s     = lock_cnt_r;
    interval_s     = interval;
    interval_vld_s = 1'b0;
    window_total_s = window_total;
    window_vld_s   = 1'b0;
    locked_s       = locked;
    err_interval_s = 1'b0;
    err_total_s    = 1'b0;
    err_cnt_s      = err_cnt;
    win_sum_s      = sat_add16(sum_r, gap_r);
    lock_inc_s     = (lock_cnt_r < LOCK_MAX) ? lock_cnt_r + 8'd1 : lock_cnt_r;

    if (clear) begin
      state_s        = IDLE;
      gap_s          = 8'd0;
      idx_s          = 8'd0;
      sum_s          = 16'd0;
      lock_cnt_s     = 8'd0;
      interval_s     = 8'd0;
      window_total_s = 16'd0;
      locked_s       = 1'b0;
      err_cnt_s      = 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (strobe_in) begin
            state_s = ACQ;
            gap_s   = 8'd1;
            idx_s   = 8'd0;
            sum_s   = 16'd0;
          end else begin
            state_s = IDLE;
          end
        end
        ACQ, TRACK: begin
          if (strobe_in) begin
            gap_s = 8'd1;
            if (gap_r < K_LO) begin
              err_interval_s = 1'b1;
              locked_s       = 1'b0;
              lock_cnt_s     = 8'd0;
              state_s        = ACQ;
              idx_s          = 8'd0;
              sum_s          = 16'd0;
            end else if (gap_r <= K_HI) begin
              interval_s     = gap_r;
              interval_vld_s = 1'b1;
              if (idx_r == LAST_IDX) begin
                window_total_s = win_sum_s;
                window_vld_s   = 1'b1;
                idx_s          = 8'd0;
                sum_s          = 16'd0;
                if (win_sum_s == SRC_TOT) begin
                  lock_cnt_s = lock_inc_s;
                  locked_s   = (lock_inc_s >= LOCK_MAX);
                  state_s    = TRACK;
                end else begin
                  err_total_s = 1'b1;
                  locked_s    = 1'b0;
                  lock_cnt_s  = 8'd0;
                  state_s     = ACQ;
                end
              end else begin
                idx_s = idx_r + 8'd1;
                sum_s = win_sum_s;
              end
            end else begin
              // Unreachable in normal flow: the timeout below fires first.
              err_interval_s = 1'b1;
              locked_s       = 1'b0;
              lock_cnt_s     = 8'd0;
              state_s        = IDLE;
            end
          end else if (gap_r >= K_HI) begin
            err_interval_s = 1'b1;
            locked_s       = 1'b0;
            lock_cnt_s     = 8'd0;
            state_s        = IDLE;
            gap_s          = 8'd0;
          end else begin
            gap_s = gap_r + 8'd1;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase

      if ((err_interval_s || err_total_s) && (err_cnt != 8'hFF)) begin
        err_cnt_s = err_cnt + 8'd1;
      end else begin
        err_cnt_s = err_cnt;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      gap_r        <= 8'd0;
      idx_r        <= 8'd0;
      sum_r        <= 16'd0;
      lock_cnt_r   <= 8'd0;
      interval     <= 8'd0;
      interval_vld <= 1'b0;
      window_total <= 16'd0;
      window_vld   <= 1'b0;
      locked       <= 1'b0;
      err_interval <= 1'b0;
      err_total    <= 1'b0;
      err_cnt      <= 8'd0;
    end else begin
      state_r      <= state_s;
      gap_r        <= gap_s;
      idx_r        <= idx_s;
      sum_r        <= sum_s;
      lock_cnt_r   <= lock_cnt_s;
      interval     <= interval_s;
      interval_vld <= interval_vld_s;
      window_total <= window_total_s;
      window_vld   <= window_vld_s;
      locked       <= locked_s;
      err_interval <= err_interval_s;
      err_total    <= err_total_s;
      err_cnt      <= err_cnt_s;
    end
  end

endmodule

// File: tb/tb_frac_strobe_monitor.sv
// Directed self-checking bench for frac_strobe_monitor (76/10 strobe train).
module tb_frac_strobe_monitor;

  logic        clk;
  logic        rst;
  logic        strobe_in;
  logic        clear;
  logic [7:0]  interval;
  logic        interval_vld;
  logic [15:0] window_total;
  logic        window_vld;
  logic        locked;
  logic        err_interval;
  logic        err_total;
  logic [7:0]  err_cnt;

  int checks = 0;
  int fails  = 0;
  int pat [10] = '{8, 8, 7, 8, 7, 8, 7, 8, 7, 8};

  frac_strobe_monitor dut (
    .clk(clk), .rst(rst), .strobe_in(strobe_in), .clear(clear),
    .interval(interval), .interval_vld(interval_vld),
    .window_total(window_total), .window_vld(window_vld),
    .locked(locked), .err_interval(err_interval), .err_total(err_total),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic s);
    strobe_in = s;
    @(posedge clk);
    #1;
    strobe_in = 1'b0;
  endtask

  task automatic send_interval(input int k);
    repeat (k - 1) step(1'b0);
    step(1'b1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0);
    clear = 1'b0;
  endtask

  // Sends one 76-cycle divider-pattern window, checking every interval and the close.
  task automatic clean_window(input string tag, input logic exp_locked);
    for (int i = 0; i < 10; i++) begin
      send_interval(pat[i]);
      checks++;
      if (interval_vld !== 1'b1 || interval !== 8'(pat[i])) begin
        fails++;
        $display("FAIL %s interval[%0d]: got vld=%0b val=%0d, want vld=1 val=%0d", tag, i, interval_vld, interval, pat[i]);
      end
    end
    checks++;
    if (window_vld !== 1'b1 || window_total !== 16'd76 || err_total !== 1'b0 || locked !== exp_locked) begin
      fails++;
      $display("FAIL %s window: got vld=%0b total=%0d err_total=%0b locked=%0b, want 1/76/0/%0b",
               tag, window_vld, window_total, err_total, locked, exp_locked);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; strobe_in = 1'b0;
    #12;
    checks++;
    if ({interval, interval_vld, window_total, window_vld, locked, err_interval, err_total, err_cnt} !== 37'd0) begin
      fails++;
      $display("FAIL reset_state: got interval=%0d total=%0d locked=%0b err_cnt=%0d, want all 0", interval, window_total, locked, err_cnt);
    end
    rst = 1'b0;
    repeat (3) step(1'b0);
    checks++;
    if (interval_vld !== 1'b0 || err_interval !== 1'b0 || err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL idle_quiet: got vld=%0b err=%0b err_cnt=%0d, want 0/0/0", interval_vld, err_interval, err_cnt);
    end
  endtask

  task automatic test_lock();
    step(1'b1);
    checks++;
    if (interval_vld !== 1'b0 || err_interval !== 1'b0) begin
      fails++;
      $display("FAIL first_strobe: got vld=%0b err=%0b, want 0/0", interval_vld, err_interval);
    end
    for (int w = 0; w < 5; w++) clean_window("lock", (w >= 3) ? 1'b1 : 1'b0);
    checks++;
    if (err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL lock_err_cnt: got %0d, want 0", err_cnt);
    end
  endtask

  task automatic test_short_interval();
    send_interval(6);
    checks++;
    if (err_interval !== 1'b1 || locked !== 1'b0 || err_cnt !== 8'd1 || interval_vld !== 1'b0) begin
      fails++;
      $display("FAIL short: got err=%0b locked=%0b err_cnt=%0d vld=%0b, want 1/0/1/0", err_interval, locked, err_cnt, interval_vld);
    end
    for (int w = 0; w < 4; w++) clean_window("relock", (w == 3) ? 1'b1 : 1'b0);
    checks++;
    if (err_cnt !== 8'd1) begin
      fails++;
      $display("FAIL relock_err_cnt: got %0d, want 1", err_cnt);
    end
  endtask

  task automatic test_late();
    do_clear();
    checks++;
    if (err_cnt !== 8'd0 || locked !== 1'b0) begin
      fails++;
      $display("FAIL clear_state: got err_cnt=%0d locked=%0b, want 0/0", err_cnt, locked);
    end
    step(1'b1);
    send_interval(8);
    repeat (7) step(1'b0);
    checks++;
    if (err_interval !== 1'b0) begin
      fails++;
      $display("FAIL late_early: got err=%0b at gap 7, want 0", err_interval);
    end
    step(1'b0);
    checks++;
    if (err_interval !== 1'b1 || err_cnt !== 8'd1) begin
      fails++;
      $display("FAIL late_err: got err=%0b err_cnt=%0d, want 1/1", err_interval, err_cnt);
    end
    step(1'b1);
    checks++;
    if (err_interval !== 1'b0 || interval_vld !== 1'b0 || err_cnt !== 8'd1) begin
      fails++;
      $display("FAIL late_restart: got err=%0b vld=%0b err_cnt=%0d, want 0/0/1", err_interval, interval_vld, err_cnt);
    end
    send_interval(7);
    checks++;
    if (interval_vld !== 1'b1 || interval !== 8'd7) begin
      fails++;
      $display("FAIL late_reacq: got vld=%0b interval=%0d, want 1/7", interval_vld, interval);
    end
  endtask

  task automatic test_bad_total();
    do_clear();
    step(1'b1);
    for (int w = 0; w < 3; w++) begin
      repeat (10) send_interval(8);
      checks++;
      if (window_vld !== 1'b1 || window_total !== 16'd80 || err_total !== 1'b1 || locked !== 1'b0 || err_cnt !== 8'(w + 1)) begin
        fails++;
        $display("FAIL bad_total[%0d]: got vld=%0b total=%0d err_total=%0b locked=%0b err_cnt=%0d, want 1/80/1/0/%0d",
                 w, window_vld, window_total, err_total, locked, err_cnt, w + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    step(1'b1);
    for (int i = 0; i < 300; i++) begin
      step(1'b1);
      checks++;
      if (err_interval !== 1'b1) begin
        fails++;
        $display("FAIL b2b_err[%0d]: got %0b, want 1", i, err_interval);
      end
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      fails++;
      $display("FAIL b2b_saturate: got %0d, want 255", err_cnt);
    end
  endtask

  task automatic test_rst_clear();
    do_clear();
    step(1'b1);
    send_interval(8);
    send_interval(3);
    send_interval(7);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({interval, interval_vld, window_total, window_vld, locked, err_interval, err_total, err_cnt} !== 37'd0) begin
      fails++;
      $display("FAIL async_rst: got interval=%0d vld=%0b err_cnt=%0d, want all 0", interval, interval_vld, err_cnt);
    end
    #3 rst = 1'b0;
    step(1'b0);
    clear = 1'b1;
    step(1'b1);
    clear = 1'b0;
    repeat (10) step(1'b0);
    checks++;
    if (err_interval !== 1'b0 || err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL clear_strobe_ignored: got err=%0b err_cnt=%0d, want 0/0", err_interval, err_cnt);
    end
    step(1'b1);
    send_interval(7);
    checks++;
    if (interval_vld !== 1'b1 || interval !== 8'd7 || err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL clear_reacq: got vld=%0b interval=%0d err_cnt=%0d, want 1/7/0", interval_vld, interval, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_short_interval();
    test_late();
    test_bad_total();
    test_back_to_back();
    test_rst_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
